alu_pipe_responder: RTL
=======================

Name: alu_pipe_responder

Overview:
- Responder end of the ALU operand/result interface; the driver side issues operand_a/operand_b/opcode requests, this block returns y/carry/zero/overflow.
- Built as a valid/ready block: one input register stage, one compute stage, and a result FIFO that absorbs output backpressure.
- Used as the pipelined DUT behind the class-based driver/monitor environment.
- Ordering is strictly in-order.

Parameters:
- WIDTH, 8, operand and result width in bits.
- DEPTH, 3, opcode width in bits.
- FIFO_DEPTH, 4, number of in-flight results, counting the input stage plus FIFO entries; must be >= 2.

Ports:
- clk  input  1  Single clock; all state updates on its rising edge.
- rst  input  1  Asynchronous, active-high reset.
- in_valid  input  1  Request present.
- in_ready  output  1  Block can accept a request.
- operand_a  input  WIDTH  Operand A.
- operand_b  input  WIDTH  Operand B.
- opcode  input  DEPTH  Operation select.
- out_valid  output  1  Result at FIFO head.
- out_ready  input  1  Consumer takes the result.
- y  output  WIDTH  Result.
- carry  output  1  Carry/borrow/shift-out flag.
- zero  output  1  Asserted when y == 0.
- overflow  output  1  Signed overflow flag.

Behaviour:
- Reset:
  - Asynchronous and active-high.
  - Clears the stage-1 valid bit, the FIFO pointers and the occupancy count.
  - While rst is high: in_ready=0, out_valid=0, and y/carry/zero/overflow read 0.
  - Reset mid-operation discards every in-flight and queued result; nothing is replayed.
- Accept: a request is taken on a rising edge with in_valid && in_ready.
- in_ready:
  - in_ready = !rst && (occ < FIFO_DEPTH), where occ = stage-1 valid + FIFO count.
  - in_ready depends only on registered state, so there is no combinational path from out_ready to in_ready.
- Pop: the head entry leaves on a rising edge with out_valid && out_ready.
- Latency:
  - A request accepted at edge N is computed from the stage-1 register and pushed at edge N+1.
  - out_valid is high in the cycle after edge N+1 when the FIFO was empty.
  - Minimum latency is 2 edges; sustained throughput is 1 per cycle while out_ready=1.
- Simultaneous events:
  - Accept, compute-push and pop may all occur on the same edge.
  - occ is updated by +accept -pop.
  - A push into a full FIFO cannot happen, because credit is counted at accept.
- Output masking: when out_valid=0, y/carry/zero/overflow are forced to 0.
- Opcodes (unsigned arithmetic, results truncated to WIDTH):
  - 0 ADD: y=a+b; carry=carry-out; overflow when both sign bits are equal and the result sign differs.
  - 1 SUB: y=a-b; carry=borrow (a<b unsigned); overflow when the sign bits differ and the result sign differs from a.
  - 2 AND, 3 OR, 4 XOR, 5 NOT (y=~a): carry=0, overflow=0.
  - 6 SHL: y=a<<1, carry=a[WIDTH-1].
  - 7 SHR: y=a>>1 (logical), carry=a[0].
  - Opcodes 6 and 7 have overflow=0.
  - Codes >= 8 (only when DEPTH > 3): y=0, carry=0, overflow=0, zero=1.
- zero = (y == 0) for every opcode; it is computed and stored with the result.
- FIFO pointers wrap modulo FIFO_DEPTH. Full and empty are taken from the count, not from pointer equality.

Optional Feature:
- Macro: ALU_TXN_CNT_EN.
- Defined:
  - Adds the output port txn_count [15:0], a registered count of output handshakes.
  - Increments on each out_valid && out_ready and wraps 16'hFFFF -> 0.
  - Reset value is 0.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Package alu_pkg holds:
  - opcode enum alu_op_e (ADD..SHR);
  - packed struct alu_result_t {y, carry, zero, overflow};
  - function alu_compute(a, b, op) returning alu_result_t, shared with the scoreboard model.
- Sub-module alu_result_fifo: a synchronous FIFO of alu_result_t with parameter FIFO_DEPTH, push/pop/count, and async active-high reset.

Test Plan:
- ADD a=8'hFF, b=8'h01, out_ready=1 -> after 2 edges out_valid=1, y=8'h00, carry=1, zero=1, overflow=0.
- SUB a=8'h80, b=8'h01 -> y=8'h7F, carry=0, overflow=1, zero=0. Then SUB a=8'h01, b=8'h02 -> y=8'hFF, carry=1, overflow=0.
- Backpressure: hold out_ready=0 and offer 6 back-to-back requests -> exactly 4 accepted and in_ready=0 thereafter. Then raise out_ready -> 4 results in order, with in_ready=1 again the cycle after the first pop.
- Streaming: 16 random ops back-to-back with out_ready=1 -> one result per cycle after the 2-edge fill, all matching alu_compute in order.
- Reset mid-stream: assert rst with 3 results queued -> out_valid=0 and y=0 immediately (asynchronous). After release, in_ready=1, and no stale result appears.
- With ALU_TXN_CNT_EN: complete 3 handshakes -> txn_count=3. Preload near 16'hFFFF (force) and pop 2 -> wraps to 1.

Source files
------------

// File: rtl/alu_pkg.sv
// ALU opcode encoding, result record and the shared combinational compute function.
package alu_pkg;

    localparam int ALU_WIDTH    = 8;
    localparam int ALU_OP_ARG_W = 8;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_NOT = 3'd5,
        ALU_SHL = 3'd6,
        ALU_SHR = 3'd7
    } alu_op_e;

    typedef struct packed {
        logic [ALU_WIDTH-1:0] y;
        logic                 carry;
        logic                 zero;
        logic                 overflow;
    } alu_result_t;

    // op is zero-extended by the caller so codes beyond the enum fall to the all-zero result
    function automatic alu_result_t alu_compute(
        input logic [ALU_WIDTH-1:0]    a,
        input logic [ALU_WIDTH-1:0]    b,
        input logic [ALU_OP_ARG_W-1:0] op
    );
        alu_result_t          r;
        logic [ALU_WIDTH:0]   ext;
        r   = '0;
        ext = '0;
        case (op)
            ALU_OP_ARG_W'(ALU_ADD): begin
                ext        = {1'b0, a} + {1'b0, b};
                r.y        = ext[ALU_WIDTH-1:0];
                r.carry    = ext[ALU_WIDTH];
                r.overflow = (a[ALU_WIDTH-1] == b[ALU_WIDTH-1]) && (r.y[ALU_WIDTH-1] != a[ALU_WIDTH-1]);
            end
            ALU_OP_ARG_W'(ALU_SUB): begin
                ext        = {1'b0, a} - {1'b0, b};
                r.y        = ext[ALU_WIDTH-1:0];
                r.carry    = ext[ALU_WIDTH];
                r.overflow = (a[ALU_WIDTH-1] != b[ALU_WIDTH-1]) && (r.y[ALU_WIDTH-1] != a[ALU_WIDTH-1]);
            end
            ALU_OP_ARG_W'(ALU_AND): r.y = a & b;
            ALU_OP_ARG_W'(ALU_OR):  r.y = a | b;
            ALU_OP_ARG_W'(ALU_XOR): r.y = a ^ b;
            ALU_OP_ARG_W'(ALU_NOT): r.y = ~a;
            ALU_OP_ARG_W'(ALU_SHL): begin
                r.y     = {a[ALU_WIDTH-2:0], 1'b0};
                r.carry = a[ALU_WIDTH-1];
            end
            ALU_OP_ARG_W'(ALU_SHR): begin
                r.y     = {1'b0, a[ALU_WIDTH-1:1]};
                r.carry = a[0];
            end
            default: r = '0;
        endcase
        r.zero = (r.y == '0);
        return r;
    endfunction

endpackage

// File: rtl/alu_result_fifo.sv
// Result FIFO of alu_result_t; push and pop in the same cycle are both honoured.
// Latency: head visible the cycle after push; backpressure is the caller's job (credit at accept).
module alu_result_fifo
    import alu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              push,
    input  alu_result_t                       push_dat,
    input  logic                              pop,
    output alu_result_t                       head_dat,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH+1);

    alu_result_t       mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH-1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];

endmodule

// File: rtl/alu_pipe_responder.sv
// Pipelined ALU responder: input register, compute, result FIFO; optional ALU_TXN_CNT_EN handshake counter.
// Latency: 2 edges accept-to-out_valid, 1 result/cycle sustained.
// Backpressure: in_ready from registered occupancy (stage 1 + FIFO) < FIFO_DEPTH; no out_ready->in_ready path.
module alu_pipe_responder
    import alu_pkg::*;
#(
    parameter int WIDTH      = ALU_WIDTH,
    parameter int DEPTH      = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [DEPTH-1:0] opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             carry,
    output logic             zero,
    output logic             overflow
`ifdef ALU_TXN_CNT_EN
    ,
    output logic [15:0]      txn_count
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH+1);

    logic             s1_vld;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [DEPTH-1:0] s1_op;
    logic             accept;
    logic             pop;
    logic [CW-1:0]    fifo_count;
    logic [CW-1:0]    occ;
    alu_result_t      push_dat;
    alu_result_t      head_dat;

    // stage 1 always drains into the FIFO next edge, so it holds a credit already
    assign occ       = CW'(s1_vld) + fifo_count;
    assign in_ready  = !rst && (occ < CW'(FIFO_DEPTH));
    assign accept    = in_valid && in_ready;
    assign out_valid = !rst && (fifo_count != '0);
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s1_a   <= '0;
            s1_b   <= '0;
            s1_op  <= '0;
        end else begin
            s1_vld <= accept;
            if (accept) begin
                s1_a  <= operand_a;
                s1_b  <= operand_b;
                s1_op <= opcode;
            end
        end
    end

    assign push_dat = alu_compute(s1_a, s1_b, ALU_OP_ARG_W'(s1_op));

    alu_result_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (s1_vld),
        .push_dat (push_dat),
        .pop      (pop),
        .head_dat (head_dat),
        .count    (fifo_count)
    );

    assign y        = out_valid ? head_dat.y        : '0;
    assign carry    = out_valid ? head_dat.carry    : 1'b0;
    assign zero     = out_valid ? head_dat.zero     : 1'b0;
    assign overflow = out_valid ? head_dat.overflow : 1'b0;

`ifdef ALU_TXN_CNT_EN
    logic [15:0] txn_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      txn_cnt_q <= '0;
        else if (pop) txn_cnt_q <= txn_cnt_q + 16'd1;
    end

    assign txn_count = txn_cnt_q;
`endif

endmodule
